// File: rtl/dea_pkg.sv
// Shared types, constants and helpers for the DEA frame cipher and any
// other block that needs the same byte transform.
package dea_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_DATA = 3'd1,
    RX_KLEN = 3'd2,
    RX_KEY  = 3'd3,
    CIPHER  = 3'd4,
    TX      = 3'd5
  } stateT;

  typedef enum logic [1:0] {
    TX_LOAD  = 2'd0,
    TX_HOLD  = 2'd1,
    TX_DRAIN = 2'd2
  } txPhaseT;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int DEF_MAX_DATA = 100;
  localparam int DEF_MAX_KEY  = 8;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] dbl;
    dbl = {v, v} << s;
    return dbl[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] dbl;
    dbl = {v, v} >> s;
    return dbl[7:0];
  endfunction

endpackage

// File: rtl/byte_cipher.sv
// Combinational single-byte transform; encrypt and decrypt are exact inverses
// for the same key byte.
module byte_cipher
  import dea_pkg::*;
(
  input  logic [7:0] data,
  input  logic [7:0] key,
  input  logic       mode,
  output logic [7:0] result
);

  // Select the transform direction
  always_comb begin
    result = 8'h00;
    case (mode)
      MODE_ENC: result = rotl8(data ^ key, key[2:0]);
      MODE_DEC: result = rotr8(data, key[2:0]) ^ key;
      default:  result = 8'h00;
    endcase
  end

endmodule

// File: rtl/dea_frame_cipher.sv
// Frame-level cipher controller: receives N + data + K + key over the UART
// handshake, ciphers the frame with a repeating key and sends the result back.
module dea_frame_cipher
  import dea_pkg::*;
#(
  parameter int MAX_DATA = DEF_MAX_DATA,
  parameter int MAX_KEY  = DEF_MAX_KEY
) (
  input  logic        Clk_100M,
  input  logic        Reset,
  input  logic        Mode,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Ready,
  output logic        Rx_Ack,
  output logic [7:0]  Tx_Data,
  output logic        Tx_Send,
  input  logic        Tx_Busy,
  input  logic        prev_pulse,
  input  logic        next_pulse,
  output logic [15:0] LEDs,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W  = cntWidth(MAX_DATA);
  localparam int KCNT_W = cntWidth(MAX_KEY);
  localparam logic [7:0]        MAX_DATA_B = 8'(MAX_DATA);
  localparam logic [7:0]        MAX_KEY_B  = 8'(MAX_KEY);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [KCNT_W-1:0] KCNT_ZERO  = KCNT_W'(0);
  localparam logic [KCNT_W-1:0] KCNT_ONE   = KCNT_W'(1);

  stateT   state, stateNext;
  txPhaseT txPhase;
  logic [CNT_W-1:0]  nLen, idx, sel, nLast;
  logic [KCNT_W-1:0] kLen, kIdx, kLast;
  logic              modeR;
  logic              rxTake, nOk, kOk;
  logic [7:0]        cipherOut;

  // Buffers are sized to the full counter range so every index is in bounds.
  logic [7:0] dataMem [0:(2**CNT_W)-1];
  logic [7:0] resMem  [0:(2**CNT_W)-1];
  logic [7:0] keyMem  [0:(2**KCNT_W)-1];

  assign rxTake = Rx_Ready & ~Rx_Ack;
  assign nOk    = (Rx_Data != 8'h00) && (Rx_Data <= MAX_DATA_B);
  assign kOk    = (Rx_Data != 8'h00) && (Rx_Data <= MAX_KEY_B);
  assign nLast  = nLen - CNT_ONE;
  assign kLast  = kLen - KCNT_ONE;
  assign LEDs   = {resMem[sel], dataMem[sel]};

  byte_cipher uCipher (
    .data   (dataMem[idx]),
    .key    (keyMem[kIdx]),
    .mode   (modeR),
    .result (cipherOut)
  );

  // State register
  always_ff @(posedge Clk_100M) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (rxTake && nOk) stateNext = RX_DATA; else stateNext = IDLE;
      RX_DATA: if (rxTake && idx == nLast) stateNext = RX_KLEN; else stateNext = RX_DATA;
      RX_KLEN: if (rxTake) stateNext = kOk ? RX_KEY : IDLE; else stateNext = RX_KLEN;
      RX_KEY:  if (rxTake && kIdx == kLast) stateNext = CIPHER; else stateNext = RX_KEY;
      CIPHER:  if (idx == nLast) stateNext = TX; else stateNext = CIPHER;
      TX:      if (txPhase == TX_DRAIN && !Tx_Busy && idx == nLast) stateNext = IDLE;
               else stateNext = TX;
      default: stateNext = IDLE;
    endcase
  end

  // Handshakes, counters, flags and sender control
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      Rx_Ack <= 1'b0; Tx_Send <= 1'b0; Tx_Data <= 8'h00; busy <= 1'b0;
      frame_err <= 1'b0; overrun <= 1'b0; modeR <= MODE_ENC;
      nLen <= CNT_ZERO; idx <= CNT_ZERO; kLen <= KCNT_ZERO; kIdx <= KCNT_ZERO;
      txPhase <= TX_LOAD;
    end else begin
      if (rxTake)         Rx_Ack <= 1'b1;
      else if (!Rx_Ready) Rx_Ack <= 1'b0;
      busy <= (stateNext != IDLE);
      case (state)
        IDLE: if (rxTake) begin
          if (nOk) begin
            nLen <= CNT_W'(Rx_Data); modeR <= Mode; frame_err <= 1'b0; idx <= CNT_ZERO;
          end else frame_err <= 1'b1;
        end
        RX_DATA: if (rxTake) idx <= (idx == nLast) ? CNT_ZERO : idx + CNT_ONE;
        RX_KLEN: if (rxTake) begin
          if (kOk) begin kLen <= KCNT_W'(Rx_Data); kIdx <= KCNT_ZERO; end
          else frame_err <= 1'b1;
        end
        RX_KEY: if (rxTake) kIdx <= (kIdx == kLast) ? KCNT_ZERO : kIdx + KCNT_ONE;
        CIPHER: begin
          if (rxTake) overrun <= 1'b1;
          idx     <= (idx == nLast) ? CNT_ZERO : idx + CNT_ONE;
          kIdx    <= (kIdx == kLast) ? KCNT_ZERO : kIdx + KCNT_ONE;
          txPhase <= TX_LOAD;
        end
        TX: begin
          if (rxTake) overrun <= 1'b1;
          case (txPhase)
            TX_LOAD:  if (!Tx_Busy) begin
              Tx_Data <= resMem[idx]; Tx_Send <= 1'b1; txPhase <= TX_HOLD;
            end
            TX_HOLD:  if (Tx_Busy) begin Tx_Send <= 1'b0; txPhase <= TX_DRAIN; end
            TX_DRAIN: if (!Tx_Busy) begin
              txPhase <= TX_LOAD; idx <= (idx == nLast) ? CNT_ZERO : idx + CNT_ONE;
            end
            default:  txPhase <= TX_LOAD;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Display selector; a new frame length restarts browsing at byte 0
  always_ff @(posedge Clk_100M) begin
    if (Reset) sel <= CNT_ZERO;
    else if (state == IDLE && rxTake && nOk) sel <= CNT_ZERO;
    else if (nLen != CNT_ZERO && next_pulse && !prev_pulse)
      sel <= (sel == nLast) ? CNT_ZERO : sel + CNT_ONE;
    else if (nLen != CNT_ZERO && prev_pulse && !next_pulse)
      sel <= (sel == CNT_ZERO) ? nLast : sel - CNT_ONE;
    else sel <= sel;
  end

  // Buffer writes; contents deliberately survive Reset
  always_ff @(posedge Clk_100M) begin
    if (!Reset && state == RX_DATA && rxTake) dataMem[idx] <= Rx_Data;
    if (!Reset && state == RX_KEY && rxTake)  keyMem[kIdx] <= Rx_Data;
    if (!Reset && state == CIPHER)            resMem[idx]  <= cipherOut;
  end

endmodule

// File: tb/tb_dea_frame_cipher.sv
// Directed bench for dea_frame_cipher with a simple UART sender model.
module tb_dea_frame_cipher;

  logic        Clk_100M, Reset, Mode;
  logic [7:0]  Rx_Data, Tx_Data;
  logic        Rx_Ready, Rx_Ack, Tx_Send, Tx_Busy;
  logic        prev_pulse, next_pulse;
  logic [15:0] LEDs;
  logic        busy, frame_err, overrun;

  int errors = 0;
  int checks = 0;
  int busyCnt = 0;
  logic [7:0] txq[$];

  dea_frame_cipher #(.MAX_DATA(100), .MAX_KEY(8)) dut (
    .Clk_100M(Clk_100M), .Reset(Reset), .Mode(Mode),
    .Rx_Data(Rx_Data), .Rx_Ready(Rx_Ready), .Rx_Ack(Rx_Ack),
    .Tx_Data(Tx_Data), .Tx_Send(Tx_Send), .Tx_Busy(Tx_Busy),
    .prev_pulse(prev_pulse), .next_pulse(next_pulse),
    .LEDs(LEDs), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  initial begin
    Clk_100M = 1'b0;
    forever #5 Clk_100M = ~Clk_100M;
  end

  // UART sender model: accepts a request, stays busy for 3 cycles
  initial begin
    Tx_Busy = 1'b0;
    forever begin
      @(posedge Clk_100M); #1;
      if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) Tx_Busy = 1'b0;
      end else if (Tx_Send === 1'b1 && Tx_Busy == 1'b0) begin
        txq.push_back(Tx_Data);
        Tx_Busy = 1'b1;
        busyCnt = 3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_100M); #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    Rx_Data = b; Rx_Ready = 1'b1;
    tick();
    n = 0;
    while (Rx_Ack !== 1'b1 && n < 20) begin tick(); n++; end
    check("rx_ack_set", 32'(Rx_Ack), 32'd1);
    Rx_Ready = 1'b0;
    tick();
    n = 0;
    while (Rx_Ack !== 1'b0 && n < 20) begin tick(); n++; end
    check("rx_ack_clr", 32'(Rx_Ack), 32'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin tick(); n++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic checkTx(input string tag, input int i, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF;
    check(tag, obs, 32'(exp));
  endtask

  task automatic pulse(input logic p, input logic nx);
    prev_pulse = p; next_pulse = nx;
    tick();
    prev_pulse = 1'b0; next_pulse = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b1; Mode = 1'b0; Rx_Data = 8'h00; Rx_Ready = 1'b0;
    prev_pulse = 1'b0; next_pulse = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("rst_rx_ack", 32'(Rx_Ack), 32'd0);
    check("rst_tx_send", 32'(Tx_Send), 32'd0);
    check("rst_tx_data", 32'(Tx_Data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Encrypt one byte
    Mode = 1'b0; txq.delete();
    sendByte(8'h01);
    check("enc_busy", 32'(busy), 32'd1);
    sendByte(8'h41); sendByte(8'h01); sendByte(8'h03);
    waitIdle();
    check("enc_count", 32'(txq.size()), 32'd1);
    checkTx("enc_byte", 0, 8'h12);
    check("enc_leds", 32'(LEDs), 32'h1241);

    // Decrypt one byte
    Mode = 1'b1; txq.delete();
    sendByte(8'h01); Mode = 1'b0;
    sendByte(8'h12); sendByte(8'h01); sendByte(8'h03);
    waitIdle();
    check("dec_count", 32'(txq.size()), 32'd1);
    checkTx("dec_byte", 0, 8'h41);

    // Key wrap over a 5-byte frame
    Mode = 1'b0; txq.delete();
    sendByte(8'h05);
    for (int i = 0; i < 5; i++) sendByte(8'h00);
    sendByte(8'h02); sendByte(8'h01); sendByte(8'h02);
    waitIdle();
    check("wrap_count", 32'(txq.size()), 32'd5);
    checkTx("wrap_b0", 0, 8'h02);
    checkTx("wrap_b1", 1, 8'h08);
    checkTx("wrap_b2", 2, 8'h02);
    checkTx("wrap_b3", 3, 8'h08);
    checkTx("wrap_b4", 4, 8'h02);

    // Length errors
    sendByte(8'h00);
    check("n0_err", 32'(frame_err), 32'd1);
    check("n0_idle", 32'(busy), 32'd0);
    sendByte(8'd101);
    check("nmax_err", 32'(frame_err), 32'd1);
    check("nmax_idle", 32'(busy), 32'd0);
    sendByte(8'h01);
    check("err_cleared", 32'(frame_err), 32'd0);
    sendByte(8'h41); sendByte(8'h09);
    check("k_err", 32'(frame_err), 32'd1);
    check("k_idle", 32'(busy), 32'd0);
    txq.delete();
    sendByte(8'h01);
    check("err_cleared2", 32'(frame_err), 32'd0);
    sendByte(8'h41); sendByte(8'h01); sendByte(8'h03);
    waitIdle();
    checkTx("after_err_byte", 0, 8'h12);

    // Extra byte while transmitting
    txq.delete();
    sendByte(8'h02); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h01); sendByte(8'h00);
    n = 0;
    while (Tx_Send !== 1'b1 && n < 50) begin tick(); n++; end
    check("tx_send_seen", 32'(Tx_Send), 32'd1);
    sendByte(8'h55);
    check("overrun_set", 32'(overrun), 32'd1);
    waitIdle();
    check("ovr_count", 32'(txq.size()), 32'd2);
    checkTx("ovr_b0", 0, 8'hAA);
    checkTx("ovr_b1", 1, 8'hBB);

    // Reset in the middle of the data bytes
    sendByte(8'h04); sendByte(8'h11); sendByte(8'h22);
    check("mid_busy", 32'(busy), 32'd1);
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    pulse(1'b0, 1'b1);
    check("n0_sel_stuck", 32'(LEDs), 32'hAA11);

    // Fresh 3-byte frame, then browse
    txq.delete();
    sendByte(8'h03); sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
    sendByte(8'h01); sendByte(8'h03);
    waitIdle();
    check("n3_count", 32'(txq.size()), 32'd3);
    checkTx("n3_b0", 0, 8'h10);
    checkTx("n3_b1", 1, 8'h08);
    checkTx("n3_b2", 2, 8'h00);
    check("sel0", 32'(LEDs), 32'h1001);
    pulse(1'b0, 1'b1);
    check("next_sel1", 32'(LEDs), 32'h0802);
    pulse(1'b0, 1'b1);
    check("next_sel2", 32'(LEDs), 32'h0003);
    pulse(1'b0, 1'b1);
    check("next_wrap0", 32'(LEDs), 32'h1001);
    pulse(1'b1, 1'b0);
    check("prev_wrap2", 32'(LEDs), 32'h0003);
    pulse(1'b1, 1'b1);
    check("both_hold", 32'(LEDs), 32'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
